// File: rtl/uat_pipe.sv
// uat_pipe: pipelined add/subtract unit, one carry-lookahead group per stage.
// An input register captures the operands; stage k then adds bit group k using
// the carry registered by stage k-1. The last stage's registers drive the outputs.
module uat_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N = WIDTH / GROUP;

  // Index 0 is the operand register. Index k+1 holds the output of stage k.
  logic [N:0]       vld;
  logic [WIDTH-1:0] ra [0:N-1];
  logic [WIDTH-1:0] rb [0:N-1];
  logic [WIDTH-1:0] rs [0:N];
  logic             rc [0:N];
  logic             ovf_q;
  logic             zero_q;

  logic [GROUP:0]   gc [0:N-1];
  logic [WIDTH-1:0] ns [0:N-1];
  logic [GROUP-1:0] p_t;
  logic [GROUP-1:0] g_t;
  logic             stall;

  // Each carry is formed directly as a sum of products of g, p and the group
  // carry-in. No carry term depends on the carry of the previous bit.
  function automatic logic [GROUP:0] cla(input logic [GROUP-1:0] p,
                                         input logic [GROUP-1:0] g,
                                         input logic             c0);
    logic [GROUP:0] c;
    logic           t;
    logic           acc;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      t = c0;
      for (int m = 0; m <= i; m++) t = t & p[m];
      acc = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        acc = acc | t;
      end
      c[i+1] = acc;
    end
    return c;
  endfunction

  // A full pipe only advances when the consumer takes the result.
  always_comb begin
    stall    = vld[N] && !out_ready;
    in_ready = !stall;
  end

  // Per-stage group sum and carries. Completed lower bits pass forward unchanged.
  always_comb begin
    p_t = '0;
    g_t = '0;
    for (int k = 0; k < N; k++) begin
      p_t   = ra[k][k*GROUP +: GROUP] ^ rb[k][k*GROUP +: GROUP];
      g_t   = ra[k][k*GROUP +: GROUP] & rb[k][k*GROUP +: GROUP];
      gc[k] = cla(p_t, g_t, rc[k]);
      ns[k] = rs[k];
      ns[k][k*GROUP +: GROUP] = p_t ^ gc[k][GROUP-1:0];
    end
  end

  // Pipeline registers. Reset wins over stall. Operands are carried at full width
  // and bits that are already consumed are left for synthesis to prune.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
      end
      for (int k = 0; k <= N; k++) begin
        rs[k] <= '0;
        rc[k] <= 1'b0;
      end
    end else if (!stall) begin
      vld[0] <= in_valid;
      ra[0]  <= a;
      rb[0]  <= op ? ~b : b;
      rc[0]  <= op ? 1'b1 : cin;
      rs[0]  <= '0;
      for (int k = 0; k < N; k++) begin
        vld[k+1] <= vld[k];
        rs[k+1]  <= ns[k];
        rc[k+1]  <= gc[k][GROUP];
      end
      for (int k = 0; k < N - 1; k++) begin
        ra[k+1] <= ra[k];
        rb[k+1] <= rb[k];
      end
      ovf_q  <= gc[N-1][GROUP] ^ gc[N-1][GROUP-1];
      zero_q <= (ns[N-1] == '0);
    end
  end

  // The last stage's registers drive the outputs directly.
  always_comb begin
    out_valid = vld[N];
    res       = rs[N];
    cout      = rc[N];
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_uat_pipe.sv
// tb_uat_pipe: directed and random checks of uat_pipe against an arithmetic model.
module tb_uat_pipe;

  localparam int W = 16;
  localparam int G = 4;
  localparam int N = W / G;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, op, out_valid, out_ready;
  logic         cout, ovf, zero;
  logic [W-1:0] a, b, res;

  logic         in_valid32, in_ready32, cin32, op32, out_valid32, out_ready32;
  logic         cout32, ovf32, zero32;
  logic [31:0]  a32, b32, res32;

  always #5 clk = ~clk;

  uat_pipe #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .cout(cout), .ovf(ovf), .zero(zero)
  );

  uat_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .op(op32), .out_valid(out_valid32),
    .out_ready(out_ready32), .res(res32), .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t         q[$];
  int           pass_cnt = 0;
  int           fail_cnt = 0;
  int           tot_cnt  = 0;
  logic         held;
  logic [W-1:0] held_res;
  logic         held_c, held_o, held_z;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tot_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: whole-word arithmetic; signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic mop);
    exp_t       e;
    logic [W:0] full;
    logic [W-1:0] beff;
    beff   = mop ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, (mop ? 1'b1 : mcin)};
    e.res  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ma[W-1] == beff[W-1]) && (e.res[W-1] != ma[W-1]);
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 16'h8000;
      3:       v = 16'h7FFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge, then check what is visible
  // before the next rising edge and update the scoreboard.
  task automatic drive(input logic r, input logic iv, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic icin, input logic iop,
                       input logic ordy);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; a = ia; b = ib; cin = icin; op = iop; out_ready = ordy;
    #1;
    chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
    if (held) begin
      chk("hold_res", res, held_res);
      chk("hold_cout", cout, held_c);
      chk("hold_ovf", ovf, held_o);
      chk("hold_zero", zero, held_z);
    end
    held     = out_valid && !out_ready && !r;
    held_res = res; held_c = cout; held_o = ovf; held_z = zero;
    if (!r && out_valid && out_ready) begin
      chk("result_expected", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("res", res, e.res);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("zero", zero, e.zero);
      end
    end
    if (r) q.delete();
    else if (iv && in_ready) q.push_back(model(ia, ib, icin, iop));
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; op32 = 1'b0; out_ready32 = 1'b1;
    held = 1'b0; held_res = '0; held_c = 1'b0; held_o = 1'b0; held_z = 1'b0;

    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_res", res, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_out_valid32", out_valid32, 1'b0);

    // Carry through every group, with the 32/8 instance launched on the same edge.
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    chk("in_ready_after_rst", in_ready, 1'b1);
    in_valid32 = 1'b1; a32 = 32'h0000FFFF; b32 = 32'h00000001;
    for (int i = 1; i <= N; i++) begin
      idle(1'b1);
      if (i == 1) in_valid32 = 1'b0;
      chk("latency_early", out_valid, 1'b0);
      chk("latency32_early", out_valid32, 1'b0);
    end
    idle(1'b1);
    chk("latency_valid", out_valid, 1'b1);
    chk("wrap_res", res, 16'h0000);
    chk("wrap_cout", cout, 1'b1);
    chk("wrap_zero", zero, 1'b1);
    chk("wrap_ovf", ovf, 1'b0);
    chk("w32_valid", out_valid32, 1'b1);
    chk("w32_res", res32, 32'h00010000);
    chk("w32_cout", cout32, 1'b0);

    // Signed overflow on add with carry-in, and subtract ignoring cin.
    drive(1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) idle(1'b1);
    chk("ovf_add_res", res, 16'h8000);
    chk("ovf_add_flag", ovf, 1'b1);
    idle(1'b1);
    chk("sub_res", res, 16'h7FFF);
    chk("sub_cout", cout, 1'b1);
    chk("sub_ovf", ovf, 1'b1);

    // Back-to-back sets with a two-cycle stall when the first result arrives.
    drive(1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'd3, 16'd4, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'd5, 16'd6, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N - 2; i++) idle(1'b1);
    idle(1'b0);
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_res", res, 16'h0003);
    chk("stall_in_ready", in_ready, 1'b0);
    idle(1'b0);
    chk("stall2_res", res, 16'h0003);
    chk("stall2_in_ready", in_ready, 1'b0);
    idle(1'b1);
    chk("order_1", res, 16'h0003);
    idle(1'b1);
    chk("order_2", res, 16'h0007);
    idle(1'b1);
    chk("order_3", res, 16'h000B);
    idle(1'b1);
    chk("no_duplicate", out_valid, 1'b0);
    chk("queue_empty_b2b", q.size(), 0);

    // Reset with two sets in flight.
    drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N + 2; i++) begin
      idle(1'b1);
      chk("flush_no_valid", out_valid, 1'b0);
    end
    drive(1'b0, 1'b1, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= N; i++) begin
      idle(1'b1);
      chk("post_rst_early", out_valid, 1'b0);
    end
    idle(1'b1);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_res", res, 16'h0FF0);

    // Random traffic with backpressure, bubbles and occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), pick(), pick(),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < N + 3; i++) idle(1'b1);
    chk("random_drained", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/uat_pipe.md
UAT_PIPE -- requirements
Module: uat_pipe

Interface
REQ-001 Parameter WIDTH, default 16; operand/result width; SHALL be an integer multiple of GROUP and >= 2*GROUP.
REQ-002 Parameter GROUP, default 4; bits per carry-lookahead group; number of pipeline stages N = WIDTH/GROUP.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  pipe can accept an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only when op=0.
REQ-010 op  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
REQ-011 out_valid  output  1  result on res/flags is valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 res  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB (op=1: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  res == 0.

Function
REQ-017 Transfer in: operand set accepted when in_valid && in_ready; transfer out: result consumed when out_valid && out_ready.
REQ-018 Stall: stall = out_valid && !out_ready; in_ready SHALL equal !stall; while stall, every pipeline register (data, carry, valid) holds its value.
REQ-019 Subtract: effective B = ~b, effective carry-in = 1; cin ignored.
REQ-020 Stage k (k = 0..N-1) SHALL compute bits [k*GROUP +: GROUP] from registered operands and the carry registered by stage k-1 (stage 0 uses effective carry-in), using per-bit propagate/generate and intra-group lookahead with no ripple chain.
REQ-021 Each stage SHALL register its group sum, group carry-out, a valid bit, and the not-yet-consumed upper operand bits; completed lower sum bits travel forward unchanged.
REQ-022 Latency: a set accepted at edge T SHALL appear on res/flags with out_valid=1 after edge T+N when no stall occurs (N=4 for defaults).
REQ-023 Throughput: one operand set per cycle when out_ready is held high; results emerge in acceptance order, none lost or duplicated.
REQ-024 Bubbles: cycles without a transfer SHALL propagate as invalid stages; out_valid=0 for the corresponding output cycle.
REQ-025 ovf SHALL equal carry into MSB XOR carry out of MSB; zero SHALL be computed from the full WIDTH-bit result.
REQ-026 res, cout, ovf, zero SHALL be registered outputs and stable while out_valid && !out_ready.
REQ-027 Simultaneous out transfer and in transfer in the same cycle SHALL both complete (full-rate flow).

Reset
REQ-028 While rst=1 at a clock edge, all stage valid bits, out_valid, res, cout, ovf and zero SHALL clear to 0 on that edge.
REQ-029 rst SHALL take priority over stall and over in_valid; in_ready SHALL be 1 in the first cycle after reset release.
REQ-030 Reset mid-operation SHALL discard every in-flight set; no result from before reset SHALL ever appear with out_valid=1.

Verification (WIDTH=16, GROUP=4 unless stated)
REQ-031 op=0, a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 4 cycles later res=0x0000, cout=1, zero=1, ovf=0.
REQ-032 op=0, a=0x7FFF, b=0x0000, cin=1 -> res=0x8000, cout=0, ovf=1, zero=0.
REQ-033 op=1, a=0x8000, b=0x0001, cin=1 -> res=0x7FFF, cout=1, ovf=1 (cin ignored).
REQ-034 Three back-to-back sets (1+2, 3+4, 5+6), out_ready low 2 cycles when first result valid -> in_ready low, res holds 0x0003, then 0x0003, 0x0007, 0x000B in order, no duplicates.
REQ-035 Two sets in flight, rst pulsed one cycle -> out_valid=0 next cycle and remains 0 until a new set's latency elapses.
REQ-036 WIDTH=32, GROUP=8: a=0x0000FFFF, b=0x00000001, op=0 -> latency 4, res=0x00010000, cout=0.
